// File: rtl/latch_arb_pkg.sv
// Shared definitions for the latch write arbiter.
//
// Contents:
//   state_t  - arbiter FSM encoding. It is exported on the top-level debug
//              port so that external checkers can follow the write window.

package latch_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // arbitrate; all strobes low
    ST_SETUP = 2'd1,  // data driven, enable still closed
    ST_OPEN  = 2'd2,  // enable high for OPEN_CYC cycles
    ST_CLOSE = 2'd3   // enable closed, data held, done pulses
  } state_t;

endpackage : latch_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//
// Finds the first set bit of req at or after index ptr, wrapping modulo N.
// req is concatenated with itself. Every bit below ptr in the lower copy is
// masked off. A plain lowest-index priority search over the 2N-bit vector
// then gives the wrapped answer without a variable rotate.
//
// Ports:
//   req     in  N          request vector
//   ptr     in  clog2(N)   index that has the highest priority this round
//   onehot  out N          one-hot winner (zero when no request)
//   idx     out clog2(N)   winner index (zero when no request)
//   any     out 1          at least one request is set

module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int PW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  int             ptr_i;
  int             sel;
  logic           found;

  assign dbl = {req, req};

  always_comb begin
    ptr_i  = int'(ptr);
    masked = '0;
    sel    = 0;
    found  = 1'b0;
    // The upper copy is never masked, so every request is still reachable
    // after the wrap.
    for (int j = 0; j < 2 * N; j++) begin
      masked[j] = dbl[j] & (j >= ptr_i);
    end
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && masked[j]) begin
        found = 1'b1;
        sel   = (j >= N) ? (j - N) : j;
      end
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = found && (sel == i);
    end
  end

  assign idx = PW'(sel);
  assign any = found;

endmodule : rr_pick

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that gives N_REQ requesters access to one transparent
// D-latch register bank.
//
// Every write follows the same fixed window:
//   SETUP (1 cycle)     : data driven, enable low
//   OPEN  (OPEN_CYC)    : enable high
//   CLOSE (1 cycle)     : enable low, data still held, done pulse to the winner
// One IDLE cycle follows each write, and the next winner is chosen in it.
// latch_en and latch_d come directly from flops. The latch bank therefore
// sees a glitch-free enable, and the data stays stable before and after it.
//
// Handshake: req is a level. A requester keeps req high until it sees its done
// bit. Only req in IDLE matters. req and req_data are sampled once, on the
// grant edge, and are ignored after that until the write completes.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-low reset
//   req        in   N_REQ      per-requester write request
//   req_data   in   N_REQ*DW   requester i data in [i*DW +: DW]
//   gnt        out  N_REQ      one-hot grant, SETUP through CLOSE
//   done       out  N_REQ      one-cycle completion pulse in CLOSE
//   latch_en   out  1          latch bank enable
//   latch_d    out  DW         latch bank data
//   busy       out  1          FSM is not idle
//   dbg_state  out  state_t    current FSM state

module latch_write_arbiter
  import latch_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int OPEN_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                latch_en,
  output logic [DW-1:0]       latch_d,
  output logic                busy,
  output state_t              dbg_state
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(OPEN_CYC + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(OPEN_CYC - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(N_REQ - 1);

  generate
    if (OPEN_CYC < 1) begin : g_bad_open_cyc
      $error("latch_write_arbiter: OPEN_CYC must be at least 1");
    end
    if (N_REQ < 2) begin : g_bad_n_req
      $error("latch_write_arbiter: N_REQ must be at least 2");
    end
  endgenerate

  // Registered state and outputs
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             en_q, en_d;
  logic [DW-1:0]    d_q, d_d;
  logic             busy_q, busy_d;

  // Round-robin choice from the live request vector
  logic [N_REQ-1:0] pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next-state logic. Each output flop is loaded with its value for the
  // coming state, so the outputs are registered and still line up with
  // the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    en_d    = 1'b0;
    d_d     = d_q;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_any) begin
          gnt_d   = pick_onehot;
          win_d   = pick_idx;
          cnt_d   = '0;
          state_d = ST_SETUP;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) begin
              d_d = req_data[i*DW +: DW];
            end
          end
        end
      end

      ST_SETUP: begin
        cnt_d   = '0;
        en_d    = 1'b1;
        state_d = ST_OPEN;
      end

      ST_OPEN: begin
        if (cnt_q == CNT_LAST) begin
          done_d  = gnt_q;
          state_d = ST_CLOSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          en_d  = 1'b1;
        end
      end

      ST_CLOSE: begin
        gnt_d   = '0;
        ptr_d   = (win_q == IDX_LAST) ? '0 : (win_q + 1'b1);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Async reset also clears latch_en at once, so a reset in the middle of a
  // window closes the latch bank without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      en_q    <= 1'b0;
      d_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      en_q    <= en_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign latch_en  = en_q;
  assign latch_d   = d_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule : latch_write_arbiter

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter (N_REQ=4, DW=8, OPEN_CYC=2, 10 ns clock).
// Inputs change 2 ns after the rising edge. Outputs are checked on the
// falling edge.
// Reference model: each write is a timeline counted in edges from its grant
// edge. The model picks winners by scanning from a pointer modulo N_REQ. It
// pushes every grant {idx,data} into exp_q, and the monitor pops one entry
// on each done pulse.

module tb_latch_write_arbiter;
  import latch_arb_pkg::*;

  localparam int N_REQ    = 4;
  localparam int DW       = 8;
  localparam int OPEN_CYC = 2;
  localparam int PW       = 2;
  localparam int W        = PW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]    req      = '0;
  logic [N_REQ*DW-1:0] req_data = '0;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                latch_en;
  logic [DW-1:0]       latch_d;
  logic                busy;
  state_t              dbg_state;

  latch_write_arbiter #(
    .N_REQ    (N_REQ),
    .DW       (DW),
    .OPEN_CYC (OPEN_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .done      (done),
    .latch_en  (latch_en),
    .latch_d   (latch_d),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];  // grants the model expects to complete
  logic [W-1:0] log_q[$];  // writes the DUT actually completed
  int           time_q[$]; // cycle number of each done pulse
  int           cyc_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model
  bit           m_active = 1'b0;
  int           m_t      = 0;
  int           m_ptr    = 0;
  int           m_w      = 0;
  logic [DW-1:0] m_d     = '0;

  always @(posedge clk) cyc_n++;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_t      = 0;
      m_ptr    = 0;
      m_w      = 0;
      m_d      = '0;
      exp_q.delete();
    end else if (m_active) begin
      m_t++;
      if (m_t == OPEN_CYC + 2) begin
        m_active = 1'b0;
        m_ptr    = (m_w + 1) % N_REQ;
      end
    end else if (req != '0) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (req[(m_ptr + k) % N_REQ]) m_w = (m_ptr + k) % N_REQ;
      end
      m_d      = req_data[m_w*DW +: DW];
      m_active = 1'b1;
      m_t      = 0;
      exp_q.push_back({PW'(m_w), m_d});
    end
  end

  // monitor / scoreboard / invariants
  logic          prev_busy = 1'b0;
  logic [DW-1:0] prev_d    = '0;

  always @(negedge clk) begin
    logic [N_REQ-1:0] eg;
    logic [PW-1:0]    di;
    logic [W-1:0]     e;
    eg = m_active ? N_REQ'(1 << m_w) : '0;
    check("busy",     32'(busy),     32'(m_active));
    check("latch_en", 32'(latch_en), 32'(m_active && m_t >= 1 && m_t <= OPEN_CYC));
    check("gnt",      32'(gnt),      32'(eg));
    check("done",     32'(done),     32'((m_active && m_t == OPEN_CYC + 1) ? eg : '0));
    check("latch_d",  32'(latch_d),  32'(m_d));
    if (done != '0) begin
      di = '0;
      for (int i = 0; i < N_REQ; i++) if (done[i]) di = PW'(i);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty: done=%0h with no expected write", done);
      end else begin
        e = exp_q.pop_front();
        check("sb_write", 32'({di, latch_d}), 32'(e));
      end
      log_q.push_back({di, latch_d});
      time_q.push_back(cyc_n);
    end
    check("inv_gnt_onehot0",  32'($onehot0(gnt)), 32'(1));
    check("inv_done_onehot0", 32'($onehot0(done)), 32'(1));
    check("inv_en_only_open", 32'(latch_en && dbg_state != ST_OPEN), 32'(0));
    check("inv_done_close",   32'((done != '0) && dbg_state != ST_CLOSE), 32'(0));
    check("inv_busy_state",   32'(busy), 32'(dbg_state != ST_IDLE));
    if (prev_busy && busy) check("inv_d_stable", 32'(latch_d), 32'(prev_d));
    prev_busy = busy;
    prev_d    = latch_d;
  end

  // drivers
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_lane(input int lane, input logic [DW-1:0] v);
    req_data[lane*DW +: DW] = v;
  endtask

  task automatic clear_logs();
    log_q.delete();
    time_q.delete();
  endtask

  initial begin
    int en_cnt;
    int busy_cnt;
    int done_cnt;

    // 1: reset with random requests
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = N_REQ'($urandom_range(0, 15));
      for (int l = 0; l < N_REQ; l++) set_lane(l, DW'($urandom));
      cyc(1);
      check("rst_outputs", 32'({gnt, done, latch_en, latch_d, busy}), 32'(0));
    end
    req = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("rst_idle_busy", 32'(busy), 32'(0));
    end

    // 2: single write
    clear_logs();
    set_lane(2, 8'hA5);
    req = 4'b0100;
    cyc(1);
    req = '0;
    check("t2_gnt", 32'(gnt), 32'(4'b0100));
    check("t2_d",   32'(latch_d), 32'(8'hA5));
    en_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (latch_en) en_cnt++;
      if (busy) busy_cnt++;
      if (done == 4'b0100) done_cnt++;
      cyc(1);
    end
    check("t2_en_cycles",   32'(en_cnt), 32'(2));
    check("t2_busy_cycles", 32'(busy_cnt), 32'(4));
    check("t2_done_cycles", 32'(done_cnt), 32'(1));
    check("t2_log_size",    32'(log_q.size()), 32'(1));
    if (log_q.size() >= 1) check("t2_log", 32'(log_q[0]), 32'({2'd2, 8'hA5}));

    // 3: round-robin with all requests held, starting from pointer 0
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    clear_logs();
    for (int l = 0; l < N_REQ; l++) set_lane(l, DW'(8'h10 + 8'h11 * l));
    req = 4'b1111;
    cyc(21);
    req = '0;
    cyc(6);
    check("t3_count", 32'(log_q.size()), 32'(5));
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      check("t3_order", 32'(log_q[i]), 32'({PW'(i % N_REQ), DW'(8'h10 + 8'h11 * (i % N_REQ))}));
      if (i > 0) check("t3_spacing", 32'(time_q[i] - time_q[i-1]), 32'(OPEN_CYC + 3));
    end

    // 4: pointer wrap (pointer is 1 here)
    clear_logs();
    req = 4'b1000;
    cyc(1);
    req = 4'b1001;
    cyc(10);
    req = '0;
    cyc(6);
    check("t4_count", 32'(log_q.size()), 32'(3));
    if (log_q.size() >= 3) begin
      check("t4_first",  32'(log_q[0][W-1:DW]), 32'(3));
      check("t4_second", 32'(log_q[1][W-1:DW]), 32'(0));
      check("t4_third",  32'(log_q[2][W-1:DW]), 32'(3));
    end

    // 5: request drops and data changes mid-window
    clear_logs();
    set_lane(1, 8'h3C);
    req = 4'b0010;
    cyc(3);
    check("t5_in_open", 32'(latch_en), 32'(1));
    req = '0;
    set_lane(1, 8'hFF);
    cyc(1);
    check("t5_d_held", 32'(latch_d), 32'(8'h3C));
    cyc(5);
    check("t5_count", 32'(log_q.size()), 32'(1));
    if (log_q.size() >= 1) check("t5_log", 32'(log_q[0]), 32'({2'd1, 8'h3C}));

    // 6: reset in the middle of a window (pointer is 2 here)
    clear_logs();
    req = 4'b1111;
    cyc(3);
    check("t6_pre_en",  32'(latch_en), 32'(1));
    check("t6_pre_gnt", 32'(gnt), 32'(4'b0100));
    rst = 1'b0;
    #1;
    check("t6_en_async",   32'(latch_en), 32'(0));
    check("t6_busy_async", 32'(busy), 32'(0));
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check("t6_first_gnt", 32'(gnt), 32'(4'b0001));
    req = '0;
    cyc(6);
    check("t6_count", 32'(log_q.size()), 32'(1));

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) req = N_REQ'($urandom_range(0, 15));
      for (int l = 0; l < N_REQ; l++) set_lane(l, DW'($urandom));
      cyc(1);
    end
    req = '0;
    cyc(8);
    check("drain_exp_q", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_latch_write_arbiter
